// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: synchronizes D+/D-, recovers bit timing from D+ edges,
// NRZI-decodes each sampled bit, and flags stuffed bits, stuffing violations and SE0.
module usb_rx_bit_decoder #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PHASE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_in,
    input  logic d_minus_in,
    input  logic rx_active,
    output logic d_edge,
    output logic d_orig,
    output logic shift_strobe,
    output logic stuff_pause,
    output logic eop,
    output logic stuff_err
);

    localparam int unsigned TIMER_W = 4;
    localparam int unsigned ONES_W  = 3;

    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_SAMPLE = TIMER_W'(SAMPLE_PHASE);
    localparam logic [ONES_W-1:0]  ONES_STUFF   = ONES_W'(6);

    logic               dp_meta;
    logic               dp_sync;
    logic               dp_prev;
    logic               dm_meta;
    logic               dm_sync;
    logic [TIMER_W-1:0] timer;
    logic               prev_level;
    logic [ONES_W-1:0]  ones_cnt;

    logic               sample_c;
    logic               se0_c;
    logic               bit_c;

    // D+ edge is decoded purely from the synchronizer and history flops.
    assign d_edge   = dp_sync ^ dp_prev;
    assign sample_c = rx_active && (timer == TIMER_SAMPLE);
    assign se0_c    = !dp_sync && !dm_sync;
    assign bit_c    = (dp_sync == prev_level);

    // Two-flop synchronizers; D+ idles high (J), D- idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_meta <= 1'b1;
            dp_sync <= 1'b1;
            dp_prev <= 1'b1;
            dm_meta <= 1'b0;
            dm_sync <= 1'b0;
        end else begin
            dp_meta <= d_plus_in;
            dp_sync <= dp_meta;
            dp_prev <= dp_sync;
            dm_meta <= d_minus_in;
            dm_sync <= dm_meta;
        end
    end

    // Bit timer resyncs on every D+ edge so the sample point tracks the transmitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (d_edge || !rx_active) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // NRZI decode and bit-stuff tracking at each sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level   <= 1'b1;
            ones_cnt     <= '0;
            d_orig       <= 1'b1;
            shift_strobe <= 1'b0;
            stuff_pause  <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            stuff_pause  <= 1'b0;
            eop          <= 1'b0;
            stuff_err    <= 1'b0;
            if (!rx_active) begin
                prev_level <= 1'b1;
                ones_cnt   <= '0;
            end else if (sample_c) begin
                if (se0_c) begin
                    eop <= 1'b1;
                end else begin
                    prev_level   <= dp_sync;
                    d_orig       <= bit_c;
                    shift_strobe <= 1'b1;
                    if (ones_cnt == ONES_STUFF) begin
                        // Bit after six ones must be a stuffed zero.
                        stuff_pause <= !bit_c;
                        stuff_err   <= bit_c;
                        ones_cnt    <= '0;
                    end else if (bit_c) begin
                        ones_cnt <= ones_cnt + ONES_W'(1);
                    end else begin
                        ones_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard bench for usb_rx_bit_decoder: line-symbol packets are driven, a bit-level
// reference model queues expected strobes/EOPs/edges, and a monitor compares them.
module tb_usb_rx_bit_decoder;

    localparam int unsigned CLKS  = 8;
    localparam int unsigned PHASE = 3;
    localparam int          LAT   = int'(PHASE) + 3;

    typedef enum logic [1:0] {SYM_J, SYM_K, SYM_SE0} sym_t;
    typedef struct { sym_t sym; bit act; int len; } item_t;
    typedef struct { bit is_eop; bit d_orig; bit pause; bit err; int cyc; } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d_plus_in = 1'b1;
    logic d_minus_in = 1'b0;
    logic rx_active = 1'b0;
    logic d_edge, d_orig, shift_strobe, stuff_pause, eop, stuff_err;

    usb_rx_bit_decoder #(
        .CLKS_PER_BIT(CLKS),
        .SAMPLE_PHASE(PHASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_plus_in   (d_plus_in),
        .d_minus_in  (d_minus_in),
        .rx_active   (rx_active),
        .d_edge      (d_edge),
        .d_orig      (d_orig),
        .shift_strobe(shift_strobe),
        .stuff_pause (stuff_pause),
        .eop         (eop),
        .stuff_err   (stuff_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;
    exp_t  out_q[$];
    int    edge_q[$];
    item_t pkt[$];

    // Reference model state: line level, NRZI reference level, run of ones, last bit.
    bit cur_dp   = 1'b1;
    bit lvl      = 1'b1;
    int run      = 0;
    bit last_bit = 1'b1;
    int exp_out  = 0;

    function automatic bit sym_dp(input sym_t s);
        return s == SYM_J;
    endfunction

    function automatic bit sym_dm(input sym_t s);
        return s == SYM_K;
    endfunction

    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Drive one line symbol for len clocks and queue what the decoder must report.
    task automatic send_sym(input sym_t s, input bit act, input int len);
        bit ndp, b, p, e;
        int k;
        ndp = sym_dp(s);
        k   = cyc + 1;
        if (ndp != cur_dp) begin
            edge_q.push_back(k + 1);
            exp_out = k + LAT;
        end else begin
            exp_out = exp_out + int'(CLKS);
        end
        if (act) begin
            if (s == SYM_SE0) begin
                out_q.push_back('{1'b1, last_bit, 1'b0, 1'b0, exp_out});
            end else begin
                b = (ndp == lvl);
                lvl = ndp;
                p = 1'b0;
                e = 1'b0;
                if (run == 6) begin
                    if (b) e = 1'b1;
                    else   p = 1'b1;
                    run = 0;
                end else begin
                    run = b ? run + 1 : 0;
                end
                last_bit = b;
                out_q.push_back('{1'b0, b, p, e, exp_out});
            end
        end else begin
            lvl = 1'b1;
            run = 0;
        end
        cur_dp     = ndp;
        d_plus_in  = ndp;
        d_minus_in = sym_dm(s);
        rx_active  = act;
        repeat (len) @(negedge clk);
    endtask

    task automatic send_list();
        foreach (pkt[i]) send_sym(pkt[i].sym, pkt[i].act, pkt[i].len);
    endtask

    // SYNC, NRZI-encoded payload, two SE0 bits, then J with rx_active dropped.
    task automatic build_packet(input bit data[$], input bit jitter);
        sym_t lv;
        pkt.delete();
        for (int i = 0; i < 8; i++) begin
            if (i == 7 || (i % 2) == 0) pkt.push_back('{SYM_K, 1'b1, int'(CLKS)});
            else                        pkt.push_back('{SYM_J, 1'b1, int'(CLKS)});
        end
        lv = SYM_K;
        foreach (data[i]) begin
            if (!data[i]) lv = (lv == SYM_K) ? SYM_J : SYM_K;
            pkt.push_back('{lv, 1'b1, int'(CLKS)});
        end
        pkt.push_back('{SYM_SE0, 1'b1, int'(CLKS)});
        pkt.push_back('{SYM_SE0, 1'b1, int'(CLKS)});
        pkt.push_back('{SYM_J, 1'b0, int'(CLKS)});
        pkt.push_back('{SYM_J, 1'b0, int'(CLKS)});
        if (jitter) begin
            for (int i = 1; i < pkt.size(); i++) begin
                if (pkt[i].act && pkt[i-1].act &&
                    sym_dp(pkt[i].sym) != sym_dp(pkt[i-1].sym) &&
                    $urandom_range(0, 3) == 0)
                    pkt[i-1].len = int'(CLKS) - 2;
            end
        end
    endtask

    task automatic do_reset();
        #1;
        rst        = 1'b1;
        d_plus_in  = 1'b1;
        d_minus_in = 1'b0;
        rx_active  = 1'b0;
        out_q.delete();
        edge_q.delete();
        cur_dp   = 1'b1;
        lvl      = 1'b1;
        run      = 0;
        last_bit = 1'b1;
        #1;
        chk("rst_d_edge", d_edge, 1'b0);
        chk("rst_shift_strobe", shift_strobe, 1'b0);
        chk("rst_stuff_pause", stuff_pause, 1'b0);
        chk("rst_eop", eop, 1'b0);
        chk("rst_stuff_err", stuff_err, 1'b0);
        chk("rst_d_orig", d_orig, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare every presented output against the scoreboard queues.
    exp_t m_e;
    int   m_c;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
                m_e = out_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_output: nothing at cyc %0d, want eop=%0b d_orig=%0b pause=%0b err=%0b",
                         m_e.cyc, m_e.is_eop, m_e.d_orig, m_e.pause, m_e.err);
            end
            while (edge_q.size() > 0 && edge_q[0] < cyc) begin
                m_c = edge_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_d_edge: d_edge low at cyc %0d, want high", m_c);
            end
            if (d_edge) begin
                checks++;
                if (edge_q.size() > 0 && edge_q[0] == cyc) begin
                    void'(edge_q.pop_front());
                end else begin
                    errors++;
                    $display("FAIL unexpected_d_edge: d_edge high at cyc %0d, want low", cyc);
                end
            end
            if (shift_strobe || eop || stuff_pause || stuff_err) begin
                checks++;
                if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
                    m_e = out_q.pop_front();
                    if (eop !== m_e.is_eop || shift_strobe !== !m_e.is_eop ||
                        d_orig !== m_e.d_orig || stuff_pause !== m_e.pause ||
                        stuff_err !== m_e.err) begin
                        errors++;
                        $display("FAIL output_event cyc %0d: got eop=%b strobe=%b d_orig=%b pause=%b err=%b, want eop=%0b strobe=%0b d_orig=%0b pause=%0b err=%0b",
                                 cyc, eop, shift_strobe, d_orig, stuff_pause, stuff_err,
                                 m_e.is_eop, !m_e.is_eop, m_e.d_orig, m_e.pause, m_e.err);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected_output cyc %0d: got eop=%b strobe=%b pause=%b err=%b, want none",
                             cyc, eop, shift_strobe, stuff_pause, stuff_err);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit data[$];
        int n;
        @(negedge clk);
        do_reset();
        mon_en = 1'b1;

        // Idle, then line activity with rx_active low: edges only, no strobes.
        send_sym(SYM_J, 1'b0, 2 * int'(CLKS));
        send_sym(SYM_K, 1'b0, int'(CLKS));
        send_sym(SYM_J, 1'b0, int'(CLKS));
        send_sym(SYM_J, 1'b0, int'(CLKS));

        // SYNC followed directly by EOP.
        data.delete();
        build_packet(data, 1'b0);
        send_list();

        // Six ones then a stuffed zero, then a one to show the run restarting.
        data = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        build_packet(data, 1'b0);
        send_list();

        // Seven ones: stuffing violation.
        data = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        build_packet(data, 1'b0);
        send_list();

        // Random payloads biased toward ones, with early edges.
        repeat (20) begin
            n = $urandom_range(8, 40);
            data.delete();
            repeat (n) data.push_back($urandom_range(0, 3) != 0);
            build_packet(data, 1'b1);
            send_list();
        end

        // Reset in the middle of a byte, then a clean packet.
        data.delete();
        repeat (16) data.push_back($urandom_range(0, 1) == 1);
        build_packet(data, 1'b0);
        while (pkt.size() > 12) void'(pkt.pop_back());
        pkt[11].len = 3;
        send_list();
        do_reset();
        send_sym(SYM_J, 1'b0, 2 * int'(CLKS));
        data = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        build_packet(data, 1'b0);
        send_list();

        repeat (3 * CLKS) @(negedge clk);
        checks++;
        if (out_q.size() != 0) begin
            errors++;
            $display("FAIL drain_outputs: %0d expected events outstanding, want 0", out_q.size());
        end
        checks++;
        if (edge_q.size() != 0) begin
            errors++;
            $display("FAIL drain_edges: %0d expected edges outstanding, want 0", edge_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_rx_bit_decoder.md
USB_RX_BIT_DECODER -- requirements
Module: usb_rx_bit_decoder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, SHALL set the clocks per USB bit period (legal range 4..16).
REQ-002 Parameter SAMPLE_PHASE, default 3, SHALL set the bit-timer value at which the line is sampled (legal range 1..CLKS_PER_BIT-2).
REQ-003 Port clk, input, 1, SHALL be the single system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: asynchronous and active-high.
REQ-005 Port d_plus_in, input, 1, SHALL be the raw asynchronous D+ line.
REQ-006 Port d_minus_in, input, 1, SHALL be the raw asynchronous D- line.
REQ-007 Port rx_active, input, 1, SHALL enable bit sampling; it is driven by the receiver control unit.
REQ-008 Port d_edge, output, 1, SHALL be a one-cycle pulse on any transition of synchronized D+.
REQ-009 Port d_orig, output, 1, SHALL be the last NRZI-decoded bit.
REQ-010 Port shift_strobe, output, 1, SHALL be a one-cycle pulse per decoded non-EOP bit; it feeds the bit/byte counter cnt_up.
REQ-011 Port stuff_pause, output, 1, SHALL be a one-cycle pulse coincident with shift_strobe when the bit is a stuffed bit; it feeds the counter pause.
REQ-012 Port eop, output, 1, SHALL be a one-cycle pulse when a sample sees SE0.
REQ-013 Port stuff_err, output, 1, SHALL be a one-cycle pulse on a bit-stuff violation.

Function
REQ-014 Each line SHALL pass a 2-flop synchronizer.
REQ-015 A third flop SHALL hold the previous synchronized D+ value.
REQ-016 d_edge SHALL equal the XOR of synchronized D+ and its previous value, decoded from registers only.
REQ-017 If d_plus_in changes before rising edge k, d_edge SHALL be high in the cycle following edge k+1.
REQ-018 The bit timer SHALL be 4 bits wide.
REQ-019 The bit timer SHALL load 0 on any clock where d_edge=1 or rx_active=0.
REQ-020 Otherwise the bit timer SHALL increment, wrapping from CLKS_PER_BIT-1 to 0.
REQ-021 A sample event SHALL occur in the cycle where timer==SAMPLE_PHASE and rx_active=1, and SHALL be treated as a sample point.
REQ-022 With d_edge in cycle E and no further edge, the timer SHALL be 0 in E+1, the sample SHALL occur in E+4 (default parameters), and the outputs SHALL pulse in E+5.
REQ-023 At a sample with synchronized D+=0 and D-=0 (SE0), eop SHALL pulse the next cycle; shift_strobe, d_orig and the ones counter SHALL be unchanged.
REQ-024 At a non-SE0 sample, the decoded bit SHALL be 1 if synchronized D+ equals prev_level and 0 otherwise.
REQ-025 At a non-SE0 sample, prev_level SHALL load synchronized D+.
REQ-026 At a non-SE0 sample, d_orig SHALL load the decoded bit and shift_strobe SHALL pulse the next cycle.
REQ-027 A 3-bit ones counter SHALL increment on each decoded 1 and clear on each decoded 0.
REQ-028 When the ones counter is 6 and the decoded bit is 0, stuff_pause SHALL pulse together with shift_strobe, and the counter SHALL clear.
REQ-029 When the ones counter is 6 and the decoded bit is 1, stuff_err SHALL pulse together with shift_strobe, and the counter SHALL clear.
REQ-030 While rx_active=0, the block SHALL produce no shift_strobe, stuff_pause, eop or stuff_err.
REQ-031 While rx_active=0, prev_level SHALL be 1 (J state) and the ones counter SHALL be 0.
REQ-032 d_edge SHALL operate regardless of rx_active.
REQ-033 On an edge arriving at any timer value, including the sample cycle itself, the timer SHALL resync to 0.
REQ-034 A sample coinciding with d_edge SHALL still be taken.
REQ-035 All pulse outputs and d_orig SHALL be registered.

Reset
REQ-036 Asserting rst SHALL immediately set the D+ synchronizer flops and the previous-value flop to 1.
REQ-037 Asserting rst SHALL immediately set the D- synchronizer flops to 0.
REQ-038 Asserting rst SHALL immediately set the timer to 0, prev_level to 1, the ones counter to 0, and d_orig to 1.
REQ-039 Asserting rst SHALL immediately set d_edge, shift_strobe, stuff_pause, eop and stuff_err to 0.
REQ-040 A reset mid-packet SHALL discard all partial state; after release, the block SHALL behave as from idle.

Verification
REQ-041 Reset: assert rst with the lines in the J state (D+=1, D-=0) -> all pulses 0 and d_orig=1, asynchronously, before the next clock.
REQ-042 SYNC: with rx_active=1, drive the line states K,J,K,J,K,J,K,K at 8 clocks each -> 8 shift_strobes exactly 8 cycles apart with d_orig=0,0,0,0,0,0,0,1, and no stuff_pause.
REQ-043 Stuffing: send six decoded 1s followed by a 0 -> the 7th shift_strobe carries stuff_pause=1, and the ones counter restarts at the next bit.
REQ-044 Violation: send seven decoded 1s -> stuff_err=1 on the 7th strobe and stuff_pause=0.
REQ-045 EOP: drive SE0 for 2 bit times, then J -> eop pulses twice, no shift_strobe during SE0, and d_orig holds its last value.
REQ-046 Jitter/reset: move one edge 2 clocks early -> the following sample occurs 4 cycles after that d_edge; assert rst mid-byte -> the next packet decodes correctly from SYNC.
